// File: rtl/histo_pkg.sv
// Shared types and helpers for the frame histogram accumulator.
// Holds the controller state encoding, bin-count sizing and saturating increment.
package histo_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_READOUT
  } state_t;

  function automatic int unsigned num_bins(input int unsigned bin_w);
    return 32'd1 << bin_w;
  endfunction

  function automatic logic [31:0] cnt_max(input int unsigned cnt_w);
    logic [32:0] m;
    m = (33'd1 << cnt_w) - 33'd1;
    return m[31:0];
  endfunction

  // Counters are at most 32 bits wide; callers truncate to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned cnt_w);
    return (cnt == cnt_max(cnt_w)) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/histo_bin_ram.sv
// Simple dual-port bin counter RAM with a one-cycle registered read.
// Contents are undefined until the owner sweeps them to zero.
module histo_bin_ram
  import histo_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = num_bins(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write value on an address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/histo_accum.sv
// Per-frame pixel histogram: pipelined RMW accumulation, then a clearing
// readout stream over valid/ready with a two-entry prefetch buffer.
module histo_accum
  import histo_pkg::*;
#(
  parameter int PIX_W = 10,
  parameter int BIN_W = 10,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_end,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             busy,
  output logic             overflow
);

  localparam logic [BIN_W-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  state_t state_reg, state_next;

  logic [BIN_W-1:0] clr_addr_reg;
  logic             drain_cnt_reg;
  logic             s1_valid_reg;
  logic [BIN_W-1:0] s1_addr_reg;
  logic             fwd_valid_reg;
  logic [BIN_W-1:0] fwd_addr_reg;
  logic [CNT_W-1:0] fwd_data_reg;
  logic             overflow_reg;
  logic [BIN_W-1:0] issue_addr_reg;
  logic             issue_done_reg;
  logic             inflight_reg;
  logic [BIN_W-1:0] inflight_bin_reg;
  logic [1:0]       fifo_cnt_reg;
  logic [BIN_W-1:0] e0_bin_reg, e1_bin_reg;
  logic [CNT_W-1:0] e0_cnt_reg, e1_cnt_reg;

  logic [BIN_W-1:0] pix_bin;
  logic             pix_take;
  logic [CNT_W-1:0] s1_old, s1_new;
  logic             pop, issue;
  logic [2:0]       occ;
  logic             ram_we;
  logic [BIN_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_q;
  logic             unused_pix;

  assign unused_pix = ^pix_data;
  assign pix_bin    = pix_data[PIX_W-1 -: BIN_W];
  assign pix_take   = (state_reg == ST_ACCUM) && pix_valid;

  // Back-to-back hits on one bin must see the value written last cycle.
  assign s1_old = (fwd_valid_reg && (fwd_addr_reg == s1_addr_reg)) ? fwd_data_reg : ram_q;
  assign s1_new = CNT_W'(sat_inc(32'(s1_old), CNT_W));

  assign rd_valid = (fifo_cnt_reg != 2'd0);
  assign rd_bin   = e0_bin_reg;
  assign rd_count = e0_cnt_reg;
  assign rd_last  = rd_valid && (e0_bin_reg == LAST_BIN);
  assign busy     = (state_reg != ST_IDLE);
  assign overflow = overflow_reg;

  assign pop = rd_valid && rd_ready;
  // Only prefetch when the landing read is guaranteed a buffer slot.
  assign occ   = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue = (state_reg == ST_READOUT) && !issue_done_reg && (occ <= 3'd1);

  assign ram_raddr = (state_reg == ST_READOUT) ? issue_addr_reg : pix_bin;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_reg;
    ram_wdata = '0;
    case (state_reg)
      ST_CLEAR:   ram_we = 1'b1;
      ST_READOUT: begin
        if (pop) begin
          ram_we    = 1'b1;
          ram_waddr = e0_bin_reg;
        end
      end
      default: begin
        if (s1_valid_reg) begin
          ram_we    = 1'b1;
          ram_waddr = s1_addr_reg;
          ram_wdata = s1_new;
        end
      end
    endcase
  end

  histo_bin_ram #(
    .ADDR_W(BIN_W),
    .DATA_W(CNT_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .q    (ram_q)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR:   if (clr_addr_reg == LAST_BIN) state_next = ST_IDLE;
      ST_IDLE:    if (frame_start) state_next = ST_ACCUM;
      ST_ACCUM:   if (frame_end) state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt_reg) state_next = ST_READOUT;
      ST_READOUT: if (pop && rd_last) state_next = ST_IDLE;
      default:    state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_CLEAR;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_reg     <= '0;
      drain_cnt_reg    <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s1_addr_reg      <= '0;
      fwd_valid_reg    <= 1'b0;
      fwd_addr_reg     <= '0;
      fwd_data_reg     <= '0;
      overflow_reg     <= 1'b0;
      issue_addr_reg   <= '0;
      issue_done_reg   <= 1'b0;
      inflight_reg     <= 1'b0;
      inflight_bin_reg <= '0;
    end else begin
      clr_addr_reg  <= (state_reg == ST_CLEAR) ? clr_addr_reg + 1'b1 : '0;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? ~drain_cnt_reg : 1'b0;
      s1_valid_reg  <= pix_take;
      s1_addr_reg   <= pix_bin;
      fwd_valid_reg <= s1_valid_reg;
      fwd_addr_reg  <= s1_addr_reg;
      fwd_data_reg  <= s1_new;
      if ((state_reg == ST_IDLE) && frame_start) overflow_reg <= 1'b0;
      else if (s1_valid_reg && (s1_old == CNT_FULL)) overflow_reg <= 1'b1;
      if (state_reg != ST_READOUT) begin
        issue_addr_reg <= '0;
        issue_done_reg <= 1'b0;
      end else if (issue) begin
        issue_addr_reg <= issue_addr_reg + 1'b1;
        issue_done_reg <= (issue_addr_reg == LAST_BIN);
      end
      inflight_reg     <= issue;
      inflight_bin_reg <= issue_addr_reg;
    end
  end

  // Two-entry buffer; entry 0 drives the outputs so stalls keep them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt_reg <= 2'd0;
      e0_bin_reg   <= '0;
      e0_cnt_reg   <= '0;
      e1_bin_reg   <= '0;
      e1_cnt_reg   <= '0;
    end else begin
      case ({inflight_reg, pop})
        2'b10: begin
          if (fifo_cnt_reg == 2'd0) begin
            e0_bin_reg <= inflight_bin_reg;
            e0_cnt_reg <= ram_q;
          end else begin
            e1_bin_reg <= inflight_bin_reg;
            e1_cnt_reg <= ram_q;
          end
          fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        end
        2'b01: begin
          e0_bin_reg   <= e1_bin_reg;
          e0_cnt_reg   <= e1_cnt_reg;
          fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_reg == 2'd1) begin
            e0_bin_reg <= inflight_bin_reg;
            e0_cnt_reg <= ram_q;
          end else begin
            e0_bin_reg <= e1_bin_reg;
            e0_cnt_reg <= e1_cnt_reg;
            e1_bin_reg <= inflight_bin_reg;
            e1_cnt_reg <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_histo_accum.sv
// Randomised bench for histo_accum against an array-based histogram model.
module tb_histo_accum;

  localparam int PIX_W = 10;
  localparam int BIN_W = 10;
  localparam int CNT_W = 24;
  localparam int NB    = 1 << BIN_W;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int S_BIN_W = 4;
  localparam int S_CNT_W = 4;
  localparam int S_NB    = 1 << S_BIN_W;
  localparam int S_MAX   = (1 << S_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             frame_start, pix_valid, frame_end, rd_ready;
  logic [PIX_W-1:0] pix_data;
  logic             rd_valid, rd_last, busy, overflow;
  logic [BIN_W-1:0] rd_bin;
  logic [CNT_W-1:0] rd_count;

  logic               s_frame_start, s_pix_valid, s_frame_end, s_rd_ready;
  logic [PIX_W-1:0]   s_pix_data;
  logic               s_rd_valid, s_rd_last, s_busy, s_overflow;
  logic [S_BIN_W-1:0] s_rd_bin;
  logic [S_CNT_W-1:0] s_rd_count;

  histo_accum #(.PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_end(frame_end), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_bin(rd_bin), .rd_count(rd_count),
    .rd_last(rd_last), .busy(busy), .overflow(overflow)
  );

  histo_accum #(.PIX_W(PIX_W), .BIN_W(S_BIN_W), .CNT_W(S_CNT_W)) dut_sat (
    .clk(clk), .rst(rst), .frame_start(s_frame_start), .pix_valid(s_pix_valid),
    .pix_data(s_pix_data), .frame_end(s_frame_end), .rd_valid(s_rd_valid),
    .rd_ready(s_rd_ready), .rd_bin(s_rd_bin), .rd_count(s_rd_count),
    .rd_last(s_rd_last), .busy(s_busy), .overflow(s_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mdl [NB];
  bit mdl_ov    = 1'b0;
  bit mdl_accum = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_clear(input string tag);
    int c = 0;
    while (busy && c < 4 * NB) begin
      @(negedge clk);
      c++;
    end
    check(tag, c, NB);
  endtask

  task automatic start_frame(input bit fe_too);
    frame_start = 1'b1;
    frame_end   = fe_too;
    @(negedge clk);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    mdl_accum   = 1'b1;
    mdl_ov      = 1'b0;
  endtask

  task automatic send_pix(input bit v, input logic [PIX_W-1:0] d, input bit fe);
    int b;
    pix_valid = v;
    pix_data  = d;
    frame_end = fe;
    if (mdl_accum && v) begin
      b = int'(d) >> (PIX_W - BIN_W);
      if (mdl[b] == MAXC) mdl_ov = 1'b1;
      else mdl[b] = mdl[b] + 1;
    end
    if (mdl_accum && fe) mdl_accum = 1'b0;
    @(negedge clk);
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  // Called on the first falling edge after frame_end was sampled.
  task automatic readout(input int stall_pct, input int abort_bin);
    int cyc = 0;
    int first = -1;
    int exp_bin = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [BIN_W-1:0] pb = '0;
    logic [CNT_W-1:0] pc = '0;
    while (!done && cyc < 20000) begin
      if (rd_valid && first < 0) first = cyc;
      if (prev_stall) begin
        check("stall_valid", rd_valid, 1);
        check("stall_bin", rd_bin, pb);
        check("stall_count", rd_count, pc);
      end
      if (abort_bin >= 0 && rd_valid && int'(rd_bin) == abort_bin) begin
        rst = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", rd_valid, 0);
        rst = 1'b0;
        rd_ready = 1'b0;
        for (int i = 0; i < NB; i++) mdl[i] = 0;
        mdl_ov = 1'b0;
        mdl_accum = 1'b0;
        wait_clear("clear_len_abort");
        return;
      end
      rd_ready = ($urandom_range(99) >= stall_pct);
      if (rd_valid && rd_ready) begin
        check("beat_bin", rd_bin, exp_bin);
        check("beat_count", rd_count, mdl[exp_bin]);
        check("beat_last", rd_last, exp_bin == NB - 1);
        mdl[exp_bin] = 0;
        if (exp_bin == NB - 1) done = 1'b1;
        exp_bin++;
      end
      prev_stall = rd_valid && !rd_ready;
      pb = rd_bin;
      pc = rd_count;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    if (!done) check("readout_timeout", 0, 1);
    check("first_valid_lat", first, 4);
    check("idle_after_ro", busy, 0);
    check("overflow_end", overflow, mdl_ov);
    if (stall_pct == 0) check("readout_len", cyc, NB + 4);
  endtask

  initial begin
    int s_exp_bin;
    int s_cyc;
    logic [PIX_W-1:0] d;
    frame_start = 0; pix_valid = 0; pix_data = '0; frame_end = 0; rd_ready = 0;
    s_frame_start = 0; s_pix_valid = 0; s_pix_data = '0; s_frame_end = 0; s_rd_ready = 0;
    for (int i = 0; i < NB; i++) mdl[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_bin", rd_bin, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 1);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    wait_clear("clear_len_por");

    // Saturation on a narrow-counter instance: 20 hits on bin 2.
    s_frame_start = 1'b1;
    @(negedge clk);
    s_frame_start = 1'b0;
    repeat (20) begin
      s_pix_valid = 1'b1;
      s_pix_data  = 10'd2 << (PIX_W - S_BIN_W);
      @(negedge clk);
    end
    s_pix_valid = 1'b0;
    s_frame_end = 1'b1;
    @(negedge clk);
    s_frame_end = 1'b0;
    s_rd_ready  = 1'b1;
    s_exp_bin = 0;
    s_cyc = 0;
    while (s_exp_bin < S_NB && s_cyc < 200) begin
      if (s_rd_valid) begin
        check("sat_bin", s_rd_bin, s_exp_bin);
        check("sat_count", s_rd_count, (s_exp_bin == 2) ? ((20 > S_MAX) ? S_MAX : 20) : 0);
        s_exp_bin++;
      end
      @(negedge clk);
      s_cyc++;
    end
    check("sat_beats", s_exp_bin, S_NB);
    check("sat_overflow", s_overflow, 1);
    s_rd_ready = 1'b0;
    s_frame_start = 1'b1;
    @(negedge clk);
    s_frame_start = 1'b0;
    check("sat_overflow_clr", s_overflow, 0);

    // Empty frame.
    start_frame(1'b0);
    send_pix(1'b0, '0, 1'b1);
    readout(0, -1);

    // Stray inputs in IDLE, frame_end coincident with frame_start, 100+1 repeats.
    send_pix(1'b1, 10'd5, 1'b1);
    start_frame(1'b1);
    check("fe_with_fs_ignored", busy, 1);
    repeat (100) send_pix(1'b1, 10'd5, 1'b0);
    send_pix(1'b0, '0, 1'b0);
    send_pix(1'b1, 10'd5, 1'b1);
    readout(0, -1);

    // Alternating bins 3 and 7, random backpressure.
    start_frame(1'b0);
    for (int i = 0; i < 100; i++) send_pix(1'b1, (i % 2) ? 10'd7 : 10'd3, i == 99);
    readout(30, -1);

    // Random mix with clustered bins for forwarding and distance-2 hits.
    start_frame(1'b0);
    repeat (400) begin
      d = $urandom_range(1) ? 10'($urandom_range(7)) : 10'($urandom);
      send_pix($urandom_range(3) != 0, d, 1'b0);
    end
    send_pix(1'b1, 10'($urandom), 1'b1);
    readout(30, -1);

    // Reset during readout at bin 100, then a fresh frame.
    start_frame(1'b0);
    repeat (200) send_pix(1'b1, 10'($urandom_range(255)), 1'b0);
    send_pix(1'b0, '0, 1'b1);
    readout(0, 100);
    start_frame(1'b0);
    repeat (150) send_pix(1'b1, 10'($urandom_range(15)), 1'b0);
    send_pix(1'b1, 10'd1023, 1'b1);
    readout(30, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
